mod_reduce_seq: RTL and testbench
=================================

# mod_reduce_seq

Parametrised sequential modular reducer for the ECC datapath: computes r = x mod m for a double-width-plus-two operand x and a run-time modulus m of up to W bits. Restoring shift-subtract, one operand bit per cycle, with valid/ready handshakes on both sides. It is the successor to the fixed-modulus reducer and serves the field multiplier and the ECEG point-arithmetic controller. It can be used with any modulus, not only the curve prime.

## Interface
- W, default `DATAWIDTH: modulus and result width in bits.
- IN_W, default 2*W+2: operand width; it must satisfy IN_W > W.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand and modulus are valid.
- in_ready  out  1  block can accept a new operand; high only in IDLE.
- x_in  in  IN_W  dividend.
- m_in  in  W  modulus; it must be nonzero.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  W  x mod m.
- err  out  1  modulus was zero; qualified by out_valid.
- busy  out  1  high when the block is not in IDLE.
- quotient  out  IN_W  floor(x/m); present only with MODRED_QUOTIENT_EN.

## Operation
- States:
  - IDLE: waits for an input handshake.
  - RUN: one reduction step per cycle.
  - DONE: holds the result until the output handshake.
- IDLE: on in_valid && in_ready, capture x_in and m_in, clear the remainder register R (W+1 bits) and the bit counter.
  - If m_in == 0, go to DONE with err=1 and R=0.
  - Otherwise go to RUN with err=0.
- RUN, per cycle, with bit = x[IN_W-1-k] for k = 0..IN_W-1:
  - t = {R[W-1:0], bit}, which is W+1 bits wide.
  - If t >= m, then R = t - m, otherwise R = t.
  - The quotient shift register takes in the bit (t >= m).
  - After step k = IN_W-1, go to DONE.
- Invariant: R < m after every step. result = R[W-1:0]. R[W] is always 0 in DONE.
- DONE: result, err and quotient are held stable. On out_ready, go to IDLE.
- Inputs x_in and m_in are ignored outside an IDLE handshake. Changing them mid-operation has no effect.
- There is no early termination: latency is the same for every nonzero modulus.

## Timing
- Reset, asynchronous and effective immediately:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - result=0, err=0, quotient=0.
  - Internal registers are cleared.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No output is produced for it.
- Accept edge is T0. For a nonzero m, out_valid rises after edge T0+IN_W, giving a latency of IN_W cycles.
- For m=0, out_valid rises after edge T0+1.
- Output handshake at edge Td (out_valid && out_ready): in_ready is high from Td onward. The next accept is possible at Td+1 at the earliest.
- Throughput is one result per IN_W+2 cycles when out_ready is held high.
- Back-to-back operation is not overlapped. in_ready and out_valid are never high together.
- in_ready, out_valid and busy are registered state decodes, with no combinational path from in_valid or out_ready.

## Configuration
- MODRED_QUOTIENT_EN defined: the quotient port and an IN_W-bit quotient shift register are built.
  - The quotient is valid with out_valid.
  - The quotient is 0 when err=1.
- MODRED_QUOTIENT_EN undefined: the port and register are absent. Remainder behaviour and timing are unchanged.

## Structure
- parameters.vh holds:
  - `DATAWIDTH, the default for W.
  - `p, the curve prime used by benches.
  - The state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- The counter width is $clog2(IN_W). It is a localparam.
- One sub-module, mod_sub_step: a combinational conditional-subtract cell. It takes t (W+1 bits) and m (W bits), and returns the new R and the quotient bit. It is reusable by a future unrolled multi-bit-per-cycle variant.

## Test plan
All cases use W=8, IN_W=18.
- x=1000, m=251 -> result=247, err=0, quotient=3; out_valid 18 cycles after accept.
- x=5, m=251 -> result=5, quotient=0; latency still 18 cycles.
- x=262143, m=251 -> result=99, quotient=1044. Also x=251, m=251 -> result=0, quotient=1.
- m=0 with any x -> out_valid 1 cycle after accept, err=1, result=0.
- Back-pressure: out_ready held low for 5 cycles in DONE -> result and err stable, in_ready=0; a new in_valid during that time is not accepted.
- Reset pulse at RUN step 9 -> outputs go to reset values immediately, with no out_valid. A following operation x=1000, m=251 completes correctly.

Source files
------------

// File: rtl/mod_reduce_seq_pkg.sv
// rtl/mod_reduce_seq_pkg.sv - shared defaults and FSM encoding for the sequential modular reducer.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef CURVE_P
`define CURVE_P 251
`endif

package mod_reduce_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_W = `DATAWIDTH;

endpackage

// File: rtl/mod_reduce_seq_sub_step.sv
// rtl/mod_reduce_seq_sub_step.sv - combinational conditional-subtract cell (one restoring step).
module mod_sub_step #(
   parameter int W = 8
) (
   input  logic [W:0]   i_t,
   input  logic [W-1:0] i_m,
   output logic [W:0]   o_r,
   output logic         o_q
);

   // One extra bit so the borrow out doubles as the t >= m comparison.
   logic [W+1:0] w_diff;

   assign w_diff = {1'b0, i_t} - {2'b00, i_m};
   assign o_q    = ~w_diff[W+1];
   assign o_r    = o_q ? w_diff[W:0] : i_t;

endmodule

// File: rtl/mod_reduce_seq.sv
// rtl/mod_reduce_seq.sv - sequential x mod m, one operand bit per cycle, valid/ready on both sides.
// Optional quotient output and shift register built when MODRED_QUOTIENT_EN is defined.
module mod_reduce_seq
   import mod_reduce_seq_pkg::*;
#(
   parameter int W    = DEFAULT_W,
   parameter int IN_W = 2*W+2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] x_in,
   input  logic [W-1:0]    m_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    result,
   output logic            err,
`ifdef MODRED_QUOTIENT_EN
   output logic [IN_W-1:0] quotient,
`endif
   output logic            busy
);

   localparam int CNT_W = $clog2(IN_W);

   state_t            r_state;
   state_t            w_next_state;
   logic [IN_W-1:0]   r_x;
   logic [W-1:0]      r_m;
   logic [W:0]        r_r;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
`ifdef MODRED_QUOTIENT_EN
   logic [IN_W-1:0]   r_q;
`endif

   logic [W:0]        w_t;
   logic [W:0]        w_step_r;
   logic              w_step_q;
   logic              w_accept;
   logic              w_step_en;
   logic              w_last;

   assign w_t       = {r_r[W-1:0], r_x[IN_W-1]};
   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_step_en = (r_state == RUN) && !r_err;
   assign w_last    = (r_cnt == CNT_W'(IN_W-1));

   mod_sub_step #(
      .W (W)
   ) u_step (
      .i_t (w_t),
      .i_m (r_m),
      .o_r (w_step_r),
      .o_q (w_step_q)
   );

   // A zero modulus still spends one cycle in RUN (without stepping) so its result
   // appears one cycle after accept, matching the documented m=0 latency.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = RUN;
         RUN:     if (r_err || w_last) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_m     <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
`ifdef MODRED_QUOTIENT_EN
         r_q     <= '0;
`endif
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_x   <= x_in;
            r_m   <= m_in;
            r_r   <= '0;
            r_cnt <= '0;
            r_err <= (m_in == '0);
`ifdef MODRED_QUOTIENT_EN
            r_q   <= '0;
`endif
         end else if (w_step_en) begin
            r_r   <= w_step_r;
            r_x   <= {r_x[IN_W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
`ifdef MODRED_QUOTIENT_EN
            r_q   <= {r_q[IN_W-2:0], w_step_q};
`endif
         end
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign result    = r_r[W-1:0];
   assign err       = r_err;

`ifdef MODRED_QUOTIENT_EN
   assign quotient = r_q;

   // R stays below m, so its top bit never carries information.
   logic w_unused_bits;
   assign w_unused_bits = r_r[W];
`else
   logic w_unused_bits;
   assign w_unused_bits = r_r[W] ^ w_step_q;
`endif

endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb/tb_mod_reduce_seq.sv - directed bench for mod_reduce_seq at W=8, IN_W=18.
module tb_mod_reduce_seq;

   localparam int W    = 8;
   localparam int IN_W = 18;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [IN_W-1:0] x_in = '0;
   logic [W-1:0]    m_in = '0;
   wire             in_ready;
   wire             out_valid;
   wire             err;
   wire             busy;
   wire [W-1:0]     result;
`ifdef MODRED_QUOTIENT_EN
   wire [IN_W-1:0]  quotient;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mod_reduce_seq #(
      .W    (W),
      .IN_W (IN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .m_in      (m_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err),
`ifdef MODRED_QUOTIENT_EN
      .quotient  (quotient),
`endif
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [IN_W-1:0] x, input logic [W-1:0] m,
                         input int exp_lat, input logic [W-1:0] exp_r, input logic exp_err,
                         input logic [IN_W-1:0] exp_q, input int hold);
      int lat;
      @(negedge clk);
      x_in     = x;
      m_in     = m;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_in     = 18'h2AAAA;
      m_in     = 8'h0B;
      check({tag, "/busy"}, busy, 1);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "/latency"}, lat, exp_lat);
      check({tag, "/result"}, result, exp_r);
      check({tag, "/err"}, err, exp_err);
      check({tag, "/in_ready_in_done"}, in_ready, 0);
`ifdef MODRED_QUOTIENT_EN
      check({tag, "/quotient"}, quotient, exp_q);
`else
      if (exp_q === 'x) $display("unexpected unknown quotient reference");
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         x_in     = 18'd777;
         m_in     = 8'd13;
         @(posedge clk);
         #1;
         check({tag, "/hold_result"}, result, exp_r);
         check({tag, "/hold_err"}, err, exp_err);
         check({tag, "/hold_in_ready"}, in_ready, 0);
         check({tag, "/hold_out_valid"}, out_valid, 1);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "/out_valid_after_hs"}, out_valid, 0);
      check({tag, "/in_ready_after_hs"}, in_ready, 1);
   endtask

   initial begin
      #12;
      check("reset/in_ready", in_ready, 1);
      check("reset/out_valid", out_valid, 0);
      check("reset/busy", busy, 0);
      check("reset/result", result, 0);
      check("reset/err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("x1000_m251", 18'd1000, 8'd251, 18, 8'd247, 1'b0, 18'd3, 0);
      run_op("x5_m251", 18'd5, 8'd251, 18, 8'd5, 1'b0, 18'd0, 0);
      run_op("xmax_m251", 18'd262143, 8'd251, 18, 8'd99, 1'b0, 18'd1044, 0);
      run_op("x251_m251", 18'd251, 8'd251, 18, 8'd0, 1'b0, 18'd1, 0);
      run_op("x200000_m7", 18'd200000, 8'd7, 18, 8'd3, 1'b0, 18'd28571, 0);
      run_op("x65535_m255", 18'd65535, 8'd255, 18, 8'd0, 1'b0, 18'd257, 0);
      run_op("m_zero", 18'd12345, 8'd0, 1, 8'd0, 1'b1, 18'd0, 0);
      run_op("backpressure", 18'd1000, 8'd251, 18, 8'd247, 1'b0, 18'd3, 5);

      repeat (2) @(posedge clk);
      #1;
      check("no_accept_during_hold/busy", busy, 0);
      check("no_accept_during_hold/in_ready", in_ready, 1);

      @(negedge clk);
      x_in     = 18'd1000;
      m_in     = 8'd251;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrun_reset/in_ready", in_ready, 1);
      check("midrun_reset/out_valid", out_valid, 0);
      check("midrun_reset/busy", busy, 0);
      check("midrun_reset/result", result, 0);
      check("midrun_reset/err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("midrun_reset/no_out_valid", out_valid, 0);

      run_op("after_reset", 18'd1000, 8'd251, 18, 8'd247, 1'b0, 18'd3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
